// File: rtl/writeback_cycle.sv
// ---------------------------------------------------------------------------
// writeback_cycle
//
// Final pipeline stage: the MEM/WB register plus the writeback datapath.
// Captures MEM-stage results, formats load data (lb/lh/lbu/lhu/lw), selects
// the writeback source and drives the register-file write port. It also
// produces the same-cycle bypass selects used by decode and counts retired
// instructions.
//
// Ports:
//   clk_i         positive-edge clock
//   rst_ni        asynchronous active-low reset (whole block)
//   WB_stall_en   1: capture MEM inputs at the clock edge, 0: hold WB register
//   WB_rst_n      asynchronous active-low flush of the WB register only
//   MEM_valid     MEM holds a real (non-bubble) instruction
//   MEM_alu_data  ALU result / load-store address
//   MEM_pc_four   PC+4 of the MEM instruction
//   MEM_ld_data   raw aligned word returned by the LSU
//   MEM_mem_en    [0]wren [1]sb [2]sh [3]sw [4]lb [5]lh [6]lbu [7]lhu [8]lw
//   MEM_wb_en     00 load, 01 alu, 10 pc+4, 11 alu
//   MEM_rd_addr   destination register index
//   MEM_rd_wren   destination write enable
//   ID_rs1_addr   decode-stage rs1 index
//   ID_rs2_addr   decode-stage rs2 index
//   WB_rd_addr    register-file write index
//   WB_rd_data    register-file write data
//   WB_rd_wren    register-file write enable (never for x0)
//   sel_rs1_wb    decode takes WB_rd_data for rs1
//   sel_rs2_wb    decode takes WB_rd_data for rs2
//   retire_count  instructions retired since rst_ni (wraps)
// ---------------------------------------------------------------------------
module writeback_cycle #(
    parameter int RETIRE_CNT_W = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    WB_stall_en,
    input  logic                    WB_rst_n,
    input  logic                    MEM_valid,
    input  logic [31:0]             MEM_alu_data,
    input  logic [31:0]             MEM_pc_four,
    input  logic [31:0]             MEM_ld_data,
    input  logic [8:0]              MEM_mem_en,
    input  logic [1:0]              MEM_wb_en,
    input  logic [4:0]              MEM_rd_addr,
    input  logic                    MEM_rd_wren,
    input  logic [4:0]              ID_rs1_addr,
    input  logic [4:0]              ID_rs2_addr,
    output logic [4:0]              WB_rd_addr,
    output logic [31:0]             WB_rd_data,
    output logic                    WB_rd_wren,
    output logic                    sel_rs1_wb,
    output logic                    sel_rs2_wb,
    output logic [RETIRE_CNT_W-1:0] retire_count
);

    typedef enum logic [1:0] {
        WB_SRC_LOAD = 2'b00,
        WB_SRC_ALU  = 2'b01,
        WB_SRC_PC4  = 2'b10,
        WB_SRC_ALU2 = 2'b11
    } wb_src_e;

    // Load-type bits kept from MEM_mem_en[8:4], re-indexed from 0.
    typedef struct packed {
        logic lw;
        logic lhu;
        logic lbu;
        logic lh;
        logic lb;
    } ld_type_t;

    logic           w_stage_rst_n;
    logic           r_valid;
    logic [31:0]    r_alu_data;
    logic [31:0]    r_pc_four;
    logic [31:0]    r_ld_data;
    ld_type_t       r_ld_type;
    wb_src_e        r_wb_src;
    logic [4:0]     r_rd_addr;
    logic           r_rd_wren;
    logic [RETIRE_CNT_W-1:0] r_retire_count;

    logic [7:0]     w_ld_byte;
    logic [15:0]    w_ld_half;
    logic [31:0]    w_ld_fmt;
    logic           w_unused_store_bits;

    // Store/write-enable bits belong to MEM; writeback never looks at them.
    assign w_unused_store_bits = ^MEM_mem_en[3:0];

    // A flush clears the WB register exactly like a full reset, so both share
    // the asynchronous clear path.
    assign w_stage_rst_n = WB_rst_n & rst_ni;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge w_stage_rst_n) begin
        if (!w_stage_rst_n) begin
            r_valid    <= 1'b0;
            r_alu_data <= '0;
            r_pc_four  <= '0;
            r_ld_data  <= '0;
            r_ld_type  <= '0;
            r_wb_src   <= WB_SRC_LOAD;
            r_rd_addr  <= '0;
            r_rd_wren  <= 1'b0;
        end else if (WB_stall_en) begin
            r_valid    <= MEM_valid;
            r_alu_data <= MEM_alu_data;
            r_pc_four  <= MEM_pc_four;
            r_ld_data  <= MEM_ld_data;
            r_ld_type  <= ld_type_t'(MEM_mem_en[8:4]);
            r_wb_src   <= wb_src_e'(MEM_wb_en);
            r_rd_addr  <= MEM_rd_addr;
            // Folding valid and the x0 check in here keeps the write port and
            // the bypass selects trivially safe downstream.
            r_rd_wren  <= MEM_rd_wren & MEM_valid & (MEM_rd_addr != 5'd0);
        end
    end

    // The counter survives a pipeline flush; only rst_ni clears it. An
    // instruction flushed at the capture edge never retires.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_retire_count <= '0;
        end else if (WB_stall_en && MEM_valid && WB_rst_n) begin
            r_retire_count <= r_retire_count + RETIRE_CNT_W'(1);
        end
    end

    // Lane extraction. A misaligned halfword simply uses alu_data[1].
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        w_ld_byte = r_ld_data[7:0];
        unique case (r_alu_data[1:0])
            2'd0: w_ld_byte = r_ld_data[7:0];
            2'd1: w_ld_byte = r_ld_data[15:8];
            2'd2: w_ld_byte = r_ld_data[23:16];
            2'd3: w_ld_byte = r_ld_data[31:24];
        endcase
        w_ld_half = r_alu_data[1] ? r_ld_data[31:16] : r_ld_data[15:0];
    end

    // Priority lw > lh > lhu > lb > lbu; no load bit yields zero.
    always_comb begin
        w_ld_fmt = '0;
        if (r_ld_type.lw) begin
            w_ld_fmt = r_ld_data;
        end else if (r_ld_type.lh) begin
            w_ld_fmt = {{16{w_ld_half[15]}}, w_ld_half};
        end else if (r_ld_type.lhu) begin
            w_ld_fmt = {16'd0, w_ld_half};
        end else if (r_ld_type.lb) begin
            w_ld_fmt = {{24{w_ld_byte[7]}}, w_ld_byte};
        end else if (r_ld_type.lbu) begin
            w_ld_fmt = {24'd0, w_ld_byte};
        end
    end

    always_comb begin
        WB_rd_data = r_alu_data;
        unique case (r_wb_src)
            WB_SRC_LOAD: WB_rd_data = w_ld_fmt;
            WB_SRC_ALU:  WB_rd_data = r_alu_data;
            WB_SRC_PC4:  WB_rd_data = r_pc_four;
            WB_SRC_ALU2: WB_rd_data = r_alu_data;
        endcase
    end

    assign WB_rd_addr   = r_rd_addr;
    assign WB_rd_wren   = r_rd_wren & r_valid;
    assign sel_rs1_wb   = WB_rd_wren & (r_rd_addr == ID_rs1_addr);
    assign sel_rs2_wb   = WB_rd_wren & (r_rd_addr == ID_rs2_addr);
    assign retire_count = r_retire_count;

endmodule

// File: tb/tb_writeback_cycle.sv
// ---------------------------------------------------------------------------
// tb_writeback_cycle
//
// Directed bench for writeback_cycle. A table of single-capture vectors covers
// load formatting, source selection, x0 handling and bypass selects; short
// hand-written sequences cover reset, stall hold, asynchronous flush and the
// retire-counter wrap (using a second instance with a 4-bit counter).
// ---------------------------------------------------------------------------
module tb_writeback_cycle;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        WB_stall_en;
    logic        WB_rst_n;
    logic        MEM_valid;
    logic [31:0] MEM_alu_data;
    logic [31:0] MEM_pc_four;
    logic [31:0] MEM_ld_data;
    logic [8:0]  MEM_mem_en;
    logic [1:0]  MEM_wb_en;
    logic [4:0]  MEM_rd_addr;
    logic        MEM_rd_wren;
    logic [4:0]  ID_rs1_addr;
    logic [4:0]  ID_rs2_addr;

    logic [4:0]  WB_rd_addr;
    logic [31:0] WB_rd_data;
    logic        WB_rd_wren;
    logic        sel_rs1_wb;
    logic        sel_rs2_wb;
    logic [31:0] retire_count;

    logic [4:0]  w4_rd_addr;
    logic [31:0] w4_rd_data;
    logic        w4_rd_wren;
    logic        w4_sel_rs1;
    logic        w4_sel_rs2;
    logic [3:0]  w4_count;

    always #5 clk_i = ~clk_i;

    writeback_cycle #(.RETIRE_CNT_W(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .WB_stall_en(WB_stall_en), .WB_rst_n(WB_rst_n),
        .MEM_valid(MEM_valid), .MEM_alu_data(MEM_alu_data), .MEM_pc_four(MEM_pc_four),
        .MEM_ld_data(MEM_ld_data), .MEM_mem_en(MEM_mem_en), .MEM_wb_en(MEM_wb_en),
        .MEM_rd_addr(MEM_rd_addr), .MEM_rd_wren(MEM_rd_wren),
        .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
        .WB_rd_addr(WB_rd_addr), .WB_rd_data(WB_rd_data), .WB_rd_wren(WB_rd_wren),
        .sel_rs1_wb(sel_rs1_wb), .sel_rs2_wb(sel_rs2_wb), .retire_count(retire_count)
    );

    writeback_cycle #(.RETIRE_CNT_W(4)) dut4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .WB_stall_en(WB_stall_en), .WB_rst_n(WB_rst_n),
        .MEM_valid(MEM_valid), .MEM_alu_data(MEM_alu_data), .MEM_pc_four(MEM_pc_four),
        .MEM_ld_data(MEM_ld_data), .MEM_mem_en(MEM_mem_en), .MEM_wb_en(MEM_wb_en),
        .MEM_rd_addr(MEM_rd_addr), .MEM_rd_wren(MEM_rd_wren),
        .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
        .WB_rd_addr(w4_rd_addr), .WB_rd_data(w4_rd_data), .WB_rd_wren(w4_rd_wren),
        .sel_rs1_wb(w4_sel_rs1), .sel_rs2_wb(w4_sel_rs2), .retire_count(w4_count)
    );

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [8:0]  mem_en;
        logic [1:0]  wb_en;
        logic [4:0]  rd;
        logic        rd_wren;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] e_data;
        logic        e_wren;
        logic        e_s1;
        logic        e_s2;
    } vec_t;

    localparam logic [31:0] LD_WORD = 32'h80FF_7F01;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_cnt  = '0;
    vec_t        vecs[$];

    function automatic vec_t mk(string n, logic v, logic [31:0] alu, logic [31:0] pc4,
                                logic [8:0] me, logic [1:0] wb, logic [4:0] rd, logic wr,
                                logic [4:0] rs1, logic [4:0] rs2, logic [31:0] ed,
                                logic ew, logic s1, logic s2);
        vec_t t;
        t.name = n; t.valid = v; t.alu = alu; t.pc4 = pc4; t.mem_en = me; t.wb_en = wb;
        t.rd = rd; t.rd_wren = wr; t.rs1 = rs1; t.rs2 = rs2;
        t.e_data = ed; t.e_wren = ew; t.e_s1 = s1; t.e_s2 = s2;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [4:0] addr, input logic [31:0] data,
                              input logic wren, input logic s1, input logic s2);
        check({name, ".rd_addr"}, 32'(WB_rd_addr), 32'(addr));
        check({name, ".rd_data"}, WB_rd_data, data);
        check({name, ".rd_wren"}, 32'(WB_rd_wren), 32'(wren));
        check({name, ".sel_rs1"}, 32'(sel_rs1_wb), 32'(s1));
        check({name, ".sel_rs2"}, 32'(sel_rs2_wb), 32'(s2));
        check({name, ".retire"}, retire_count, exp_cnt);
        check({name, ".retire4"}, 32'(w4_count), 32'(exp_cnt[3:0]));
    endtask

    // Model of the retire counter is updated from the inputs present at the
    // capture edge; outputs are sampled 1 time unit after the edge.
    task automatic step();
        if (WB_stall_en && MEM_valid && WB_rst_n && rst_ni) exp_cnt = exp_cnt + 1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply(input vec_t t);
        MEM_valid    = t.valid;
        MEM_alu_data = t.alu;
        MEM_pc_four  = t.pc4;
        MEM_ld_data  = LD_WORD;
        MEM_mem_en   = t.mem_en;
        MEM_wb_en    = t.wb_en;
        MEM_rd_addr  = t.rd;
        MEM_rd_wren  = t.rd_wren;
        ID_rs1_addr  = t.rs1;
        ID_rs2_addr  = t.rs2;
    endtask

    initial begin
        // ---- reset with every input nonzero ----
        rst_ni = 1'b0; WB_rst_n = 1'b1; WB_stall_en = 1'b1;
        MEM_valid = 1'b1; MEM_alu_data = 32'hFFFF_FFFF; MEM_pc_four = 32'h1234_5678;
        MEM_ld_data = 32'hA5A5_A5A5; MEM_mem_en = 9'h1FF; MEM_wb_en = 2'b10;
        MEM_rd_addr = 5'd3; MEM_rd_wren = 1'b1; ID_rs1_addr = 5'd3; ID_rs2_addr = 5'd3;
        #22;
        check_outs("reset", 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);

        // ---- directed vectors ----
        vecs.push_back(mk("alu_first",     1, 32'h1234_5678, 32'h200, 9'h000, 2'b01, 5'd5,  1, 5'd5, 5'd0, 32'h1234_5678, 1, 1, 0));
        vecs.push_back(mk("lb_lane3",      1, 32'h3,         32'h200, 9'h010, 2'b00, 5'd6,  1, 5'd0, 5'd6, 32'hFFFF_FF80, 1, 0, 1));
        vecs.push_back(mk("lbu_lane2",     1, 32'h2,         32'h200, 9'h040, 2'b00, 5'd10, 1, 5'd0, 5'd0, 32'h0000_00FF, 1, 0, 0));
        vecs.push_back(mk("lh_lo",         1, 32'h0,         32'h200, 9'h020, 2'b00, 5'd10, 1, 5'd0, 5'd0, 32'h0000_7F01, 1, 0, 0));
        vecs.push_back(mk("lhu_hi",        1, 32'h2,         32'h200, 9'h080, 2'b00, 5'd10, 1, 5'd0, 5'd0, 32'h0000_80FF, 1, 0, 0));
        vecs.push_back(mk("lw",            1, 32'h0,         32'h200, 9'h100, 2'b00, 5'd10, 1, 5'd0, 5'd0, 32'h80FF_7F01, 1, 0, 0));
        vecs.push_back(mk("lh_hi_sign",    1, 32'h2,         32'h200, 9'h020, 2'b00, 5'd10, 1, 5'd0, 5'd0, 32'hFFFF_80FF, 1, 0, 0));
        vecs.push_back(mk("lh_misaligned", 1, 32'h3,         32'h200, 9'h020, 2'b00, 5'd10, 1, 5'd0, 5'd0, 32'hFFFF_80FF, 1, 0, 0));
        vecs.push_back(mk("lb_lane0",      1, 32'h0,         32'h200, 9'h010, 2'b00, 5'd10, 1, 5'd0, 5'd0, 32'h0000_0001, 1, 0, 0));
        vecs.push_back(mk("lbu_lane1",     1, 32'h1,         32'h200, 9'h040, 2'b00, 5'd10, 1, 5'd0, 5'd0, 32'h0000_007F, 1, 0, 0));
        vecs.push_back(mk("prio_lw_lb",    1, 32'h3,         32'h200, 9'h110, 2'b00, 5'd10, 1, 5'd0, 5'd0, 32'h80FF_7F01, 1, 0, 0));
        vecs.push_back(mk("prio_lh_lbu",   1, 32'h0,         32'h200, 9'h060, 2'b00, 5'd10, 1, 5'd0, 5'd0, 32'h0000_7F01, 1, 0, 0));
        vecs.push_back(mk("prio_lhu_lb",   1, 32'h3,         32'h200, 9'h090, 2'b00, 5'd10, 1, 5'd0, 5'd0, 32'h0000_80FF, 1, 0, 0));
        vecs.push_back(mk("no_load_bits",  1, 32'h3,         32'h200, 9'h00F, 2'b00, 5'd10, 1, 5'd0, 5'd0, 32'h0000_0000, 1, 0, 0));
        vecs.push_back(mk("src_pc4",       1, 32'hABC,       32'h104, 9'h000, 2'b10, 5'd11, 1, 5'd0, 5'd0, 32'h0000_0104, 1, 0, 0));
        vecs.push_back(mk("src_alu_11",    1, 32'hDEAD_BEEF, 32'h104, 9'h000, 2'b11, 5'd11, 1, 5'd0, 5'd0, 32'hDEAD_BEEF, 1, 0, 0));
        vecs.push_back(mk("x0_write",      1, 32'h55,        32'h200, 9'h000, 2'b01, 5'd0,  1, 5'd0, 5'd0, 32'h0000_0055, 0, 0, 0));
        vecs.push_back(mk("bubble",        0, 32'h66,        32'h200, 9'h000, 2'b01, 5'd9,  1, 5'd9, 5'd9, 32'h0000_0066, 0, 0, 0));
        vecs.push_back(mk("no_wren",       1, 32'h77,        32'h200, 9'h000, 2'b01, 5'd9,  0, 5'd9, 5'd9, 32'h0000_0077, 0, 0, 0));
        vecs.push_back(mk("bypass_x7",     1, 32'h7777,      32'h200, 9'h000, 2'b01, 5'd7,  1, 5'd7, 5'd3, 32'h0000_7777, 1, 1, 0));

        // Release reset mid-cycle with the first vector already on the inputs.
        apply(vecs[0]);
        #2 rst_ni = 1'b1;
        foreach (vecs[i]) begin
            apply(vecs[i]);
            step();
            check_outs(vecs[i].name, vecs[i].rd, vecs[i].e_data,
                       vecs[i].e_wren, vecs[i].e_s1, vecs[i].e_s2);
        end

        // ---- rs2 select follows ID_rs2_addr without a clock edge ----
        ID_rs2_addr = 5'd7;
        #1;
        check_outs("bypass_rs2_comb", 5'd7, 32'h7777, 1'b1, 1'b1, 1'b1);

        // ---- stall: three cycles of changing inputs, everything holds ----
        WB_stall_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            MEM_valid    = 1'b1;
            MEM_alu_data = 32'hC0DE_0000 + 32'(i);
            MEM_rd_addr  = 5'(i + 12);
            MEM_wb_en    = 2'(i);
            step();
            check_outs("stall_hold", 5'd7, 32'h7777, 1'b1, 1'b1, 1'b1);
        end

        // ---- asynchronous flush pulse mid-cycle ----
        #2 WB_rst_n = 1'b0;
        #1;
        check_outs("flush_async", 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1 WB_rst_n = 1'b1;
        #1;
        check_outs("flush_release", 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);

        // ---- flush together with stall_en: register stays 0, no retire ----
        WB_rst_n = 1'b0; WB_stall_en = 1'b1;
        apply(vecs[0]);
        step();
        check_outs("flush_and_stall", 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        WB_rst_n = 1'b1;
        step();
        check_outs("after_flush", 5'd5, 32'h1234_5678, 1'b1, 1'b1, 1'b0);

        // ---- 4-bit counter wrap ----
        for (int i = 0; i < 16 && exp_cnt[3:0] != 4'hF; i++) step();
        check("wrap_pre", 32'(w4_count), 32'h0000_000F);
        step();
        check("wrap_zero", 32'(w4_count), 32'h0000_0000);
        for (int i = 0; i < 16; i++) step();
        check("wrap_16_more", 32'(w4_count), 32'h0000_0000);
        check("retire32_after_wrap", retire_count, exp_cnt);

        // ---- bubbles: no increment, no write ----
        MEM_valid = 1'b0; MEM_rd_addr = 5'd4; MEM_rd_wren = 1'b1; ID_rs1_addr = 5'd4;
        for (int i = 0; i < 3; i++) begin
            step();
            check_outs("bubble_seq", 5'd4, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
